// File: rtl/imem_responder.sv
// Instruction-memory responder: single-outstanding fetch target with a
// programmable response latency, fault detection and flush/reset cancellation.
package riscv_pkg;
  localparam int XLEN = 32;
endpackage

module imem_responder #(
  parameter int          XLEN      = riscv_pkg::XLEN,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter string       INIT_FILE = "imem.hex",
  parameter logic [31:0] NOP       = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            rsp_valid,
  output logic [31:0]     rsp_instr,
  output logic [XLEN-1:0] rsp_addr,
  output logic            rsp_fault,
  output logic            busy
);
  localparam int              AW       = $clog2(DEPTH);
  localparam logic [1:0]      S_IDLE   = 2'd0;
  localparam logic [1:0]      S_WAIT   = 2'd1;
  localparam logic [1:0]      S_RESP   = 2'd2;
  localparam logic [XLEN:0]   LIMIT    = (XLEN+1)'(DEPTH) << 2;
  localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_addr;
  logic [31:0]     r_rsp_instr;
  logic [XLEN-1:0] r_rsp_addr;
  logic            r_rsp_fault;
  logic [31:0]     r_mem [0:DEPTH-1];

  logic            w_accept;
  logic            w_load;
  logic            w_fault;
  logic [XLEN-1:0] w_src;
  logic [31:0]     w_word;

  // Ready/valid depend only on state, flush and reset -- never on the request.
  assign req_ready = rst && !flush && (r_state != S_WAIT);
  assign rsp_valid = rst && !flush && (r_state == S_RESP);
  assign busy      = rst && (r_state != S_IDLE);
  assign w_accept  = req_valid && req_ready;

  // LATENCY=1 loads straight from the live request; otherwise from the captured address.
  assign w_src   = (r_state == S_WAIT) ? r_addr : req_addr;
  assign w_fault = (w_src[1:0] != 2'b00) || ({1'b0, w_src} >= LIMIT);
  assign w_word  = r_mem[w_src[2 +: AW]];
  assign w_load  = ((r_state == S_WAIT) && (r_cnt <= 4'd1)) ||
                   ((LATENCY == 1) && w_accept);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_rsp_instr <= NOP;
      r_rsp_addr  <= '0;
      r_rsp_fault <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_state <= S_RESP;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          if (w_accept) begin
            r_addr <= req_addr;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
      if (w_load) begin
        r_rsp_instr <= w_fault ? NOP : w_word;
        r_rsp_addr  <= w_src;
        r_rsp_fault <= w_fault;
      end
    end
  end

  assign rsp_instr = r_rsp_instr;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_fault = r_rsp_fault;
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: four instances at LATENCY 1..4 (lane k has LATENCY k+1),
// directed scenarios plus randomized traffic against a transaction-level model.
module tb_imem_responder;
  localparam int          NL  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                 clk = 1'b0;
  logic [NL-1:0]        rst = '0;
  logic [NL-1:0]        req_valid = '0;
  logic [NL-1:0]        flush = '0;
  logic [NL-1:0][31:0]  req_addr = '0;
  logic [NL-1:0]        req_ready, rsp_valid, rsp_fault, busy;
  logic [NL-1:0][31:0]  rsp_instr, rsp_addr;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: per lane, the cycle in which the pending response appears (-1 = none).
  int          m_rsp [NL];
  logic [31:0] m_txn [NL];
  logic [31:0] m_instr [NL];
  logic [31:0] m_addr [NL];
  logic        m_fault [NL];

  always #5 clk = ~clk;

  function automatic logic [31:0] img(int i);
    if (i == 3) return 32'h0050_0093;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic is_fault(logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] exp_word(logic [31:0] a);
    if (is_fault(a)) return NOP;
    return img(int'(a / 4));
  endfunction

  function automatic logic exp_ready(int k);
    return rst[k] && !flush[k] && !(m_rsp[k] > cyc);
  endfunction

  function automatic logic exp_valid(int k);
    return rst[k] && !flush[k] && (m_rsp[k] == cyc);
  endfunction

  function automatic logic exp_busy(int k);
    return rst[k] && (m_rsp[k] >= cyc);
  endfunction

  for (genvar g = 0; g < NL; g++) begin : gen_lane
    imem_responder #(.XLEN(32), .DEPTH(1024), .LATENCY(g + 1), .INIT_FILE(""), .NOP(NOP)) dut (
      .clk(clk), .rst(rst[g]), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_addr(req_addr[g]), .flush(flush[g]), .rsp_valid(rsp_valid[g]),
      .rsp_instr(rsp_instr[g]), .rsp_addr(rsp_addr[g]), .rsp_fault(rsp_fault[g]), .busy(busy[g])
    );
    initial for (int i = 0; i < 1024; i++) dut.r_mem[i] = img(i);
  end

  task automatic set_in(int k, logic r, logic v, logic [31:0] a, logic f);
    rst[k] = r; req_valid[k] = v; req_addr[k] = a; flush[k] = f;
  endtask

  // Advance the model across the coming edge, then move just past it.
  task automatic tick();
    for (int k = 0; k < NL; k++) begin
      logic acc;
      acc = req_valid[k] && exp_ready(k);
      if (!rst[k]) begin
        m_rsp[k] = -1; m_instr[k] = NOP; m_addr[k] = '0; m_fault[k] = 1'b0;
      end else begin
        if (flush[k] && m_rsp[k] > cyc) m_rsp[k] = -1;
        if (acc) begin
          m_rsp[k] = cyc + k + 1;
          m_txn[k] = req_addr[k];
        end
        if (m_rsp[k] == cyc + 1) begin
          m_addr[k]  = m_txn[k];
          m_fault[k] = is_fault(m_txn[k]);
          m_instr[k] = exp_word(m_txn[k]);
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 1023)) << 2;
      1: return (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
      2: return 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      3: return 32'h0000_0FFC;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < NL; k++) set_in(k, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      n_chk++; if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready[1]); end
      n_chk++; if (rsp_valid[1] !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rsp_valid[1]); end
      if (c > 0) begin
        n_chk++; if (rsp_instr[1] !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", rsp_instr[1], NOP); end
        n_chk++; if (rsp_addr[1] !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", rsp_addr[1]); end
      end
      tick();
    end
    for (int k = 0; k < NL; k++) set_in(k, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < NL; k++) begin
      n_chk++; if (req_ready[k] !== 1'b1) begin n_fail++; $display("FAIL release_ready lane %0d: got %b want 1", k, req_ready[k]); end
      n_chk++; if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL release_busy lane %0d: got %b want 0", k, busy[k]); end
    end
    tick();
  endtask

  task automatic test_basic_fetch();
    set_in(1, 1'b1, 1'b1, 32'h0000_000C, 1'b0);
    @(negedge clk);
    n_chk++; if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL fetch_ready_idle: got %b want 1", req_ready[1]); end
    tick();
    set_in(1, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_chk++; if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL fetch_ready_wait: got %b want 0", req_ready[1]); end
    n_chk++; if (rsp_valid[1] !== 1'b0) begin n_fail++; $display("FAIL fetch_early_valid: got %b want 0", rsp_valid[1]); end
    n_chk++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL fetch_busy: got %b want 1", busy[1]); end
    tick();
    @(negedge clk);
    n_chk++; if (rsp_valid[1] !== 1'b1) begin n_fail++; $display("FAIL fetch_valid: got %b want 1", rsp_valid[1]); end
    n_chk++; if (rsp_instr[1] !== 32'h0050_0093) begin n_fail++; $display("FAIL fetch_instr: got %h want 00500093", rsp_instr[1]); end
    n_chk++; if (rsp_addr[1] !== 32'h0000_000C) begin n_fail++; $display("FAIL fetch_addr: got %h want 0000000c", rsp_addr[1]); end
    n_chk++; if (rsp_fault[1] !== 1'b0) begin n_fail++; $display("FAIL fetch_fault: got %b want 0", rsp_fault[1]); end
    tick();
    @(negedge clk);
    n_chk++; if (rsp_valid[1] !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse_width: got %b want 0", rsp_valid[1]); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
    for (int c = 0; c < 5; c++) begin
      set_in(0, 1'b1, c < 3, (c < 3) ? addrs[c] : 32'h0, 1'b0);
      @(negedge clk);
      if (c < 4) begin
        n_chk++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready c%0d: got %b want 1", c, req_ready[0]); end
      end
      n_chk++; if (rsp_valid[0] !== (c >= 1 && c <= 3)) begin n_fail++; $display("FAIL b2b_valid c%0d: got %b want %b", c, rsp_valid[0], (c >= 1 && c <= 3)); end
      if (c >= 1 && c <= 3) begin
        n_chk++; if (rsp_addr[0] !== addrs[c-1]) begin n_fail++; $display("FAIL b2b_addr c%0d: got %h want %h", c, rsp_addr[0], addrs[c-1]); end
        n_chk++; if (rsp_instr[0] !== img(c-1)) begin n_fail++; $display("FAIL b2b_instr c%0d: got %h want %h", c, rsp_instr[0], img(c-1)); end
      end
      tick();
    end
  endtask

  task automatic test_faults();
    logic [31:0] fa [2] = '{32'h0000_0006, 32'h0000_1000};
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1'b1, 1'b1, fa[i], 1'b0);
      @(negedge clk); tick();
      set_in(1, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk); tick();
      @(negedge clk);
      n_chk++; if (rsp_valid[1] !== 1'b1) begin n_fail++; $display("FAIL fault_valid %0d: got %b want 1", i, rsp_valid[1]); end
      n_chk++; if (rsp_fault[1] !== 1'b1) begin n_fail++; $display("FAIL fault_flag %0d: got %b want 1", i, rsp_fault[1]); end
      n_chk++; if (rsp_instr[1] !== NOP) begin n_fail++; $display("FAIL fault_instr %0d: got %h want %h", i, rsp_instr[1], NOP); end
      n_chk++; if (rsp_addr[1] !== fa[i]) begin n_fail++; $display("FAIL fault_addr %0d: got %h want %h", i, rsp_addr[1], fa[i]); end
      tick();
    end
  endtask

  task automatic test_flush();
    set_in(2, 1'b1, 1'b1, 32'h0000_0010, 1'b0);
    @(negedge clk); tick();
    set_in(2, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    n_chk++; if (req_ready[2] !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", req_ready[2]); end
    n_chk++; if (rsp_valid[2] !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", rsp_valid[2]); end
    tick();
    set_in(2, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
    @(negedge clk);
    n_chk++; if (req_ready[2] !== 1'b1) begin n_fail++; $display("FAIL flush_reissue_ready: got %b want 1", req_ready[2]); end
    n_chk++; if (busy[2] !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy[2]); end
    tick();
    set_in(2, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++; if (rsp_valid[2] !== (c == 2)) begin n_fail++; $display("FAIL flush_rsp_timing c%0d: got %b want %b", c, rsp_valid[2], (c == 2)); end
      if (c == 2) begin
        n_chk++; if (rsp_addr[2] !== 32'h0000_0040) begin n_fail++; $display("FAIL flush_rsp_addr: got %h want 00000040", rsp_addr[2]); end
        n_chk++; if (rsp_instr[2] !== img(16)) begin n_fail++; $display("FAIL flush_rsp_instr: got %h want %h", rsp_instr[2], img(16)); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midwait();
    set_in(3, 1'b1, 1'b1, 32'h0000_0020, 1'b0);
    @(negedge clk); tick();
    set_in(3, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_chk++; if (busy[3] !== 1'b1) begin n_fail++; $display("FAIL midwait_busy: got %b want 1", busy[3]); end
    tick();
    set_in(3, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk); tick();
    set_in(3, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_chk++; if (busy[3] !== 1'b0) begin n_fail++; $display("FAIL midwait_release_busy: got %b want 0", busy[3]); end
    n_chk++; if (req_ready[3] !== 1'b1) begin n_fail++; $display("FAIL midwait_release_ready: got %b want 1", req_ready[3]); end
    for (int c = 0; c < 6; c++) begin
      n_chk++; if (rsp_valid[3] !== 1'b0) begin n_fail++; $display("FAIL midwait_ghost_rsp c%0d: got %b want 0", c, rsp_valid[3]); end
      tick();
      @(negedge clk);
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < NL; k++) begin
      for (int n = 0; n < 250; n++) begin
        set_in(k, $urandom_range(0, 39) != 0, $urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 7) == 0);
        @(negedge clk);
        n_chk++; if (req_ready[k] !== exp_ready(k)) begin n_fail++; $display("FAIL rnd_ready L%0d n%0d: got %b want %b", k+1, n, req_ready[k], exp_ready(k)); end
        n_chk++; if (rsp_valid[k] !== exp_valid(k)) begin n_fail++; $display("FAIL rnd_valid L%0d n%0d: got %b want %b", k+1, n, rsp_valid[k], exp_valid(k)); end
        n_chk++; if (busy[k] !== exp_busy(k)) begin n_fail++; $display("FAIL rnd_busy L%0d n%0d: got %b want %b", k+1, n, busy[k], exp_busy(k)); end
        n_chk++; if (rsp_instr[k] !== m_instr[k]) begin n_fail++; $display("FAIL rnd_instr L%0d n%0d: got %h want %h", k+1, n, rsp_instr[k], m_instr[k]); end
        n_chk++; if (rsp_addr[k] !== m_addr[k]) begin n_fail++; $display("FAIL rnd_addr L%0d n%0d: got %h want %h", k+1, n, rsp_addr[k], m_addr[k]); end
        n_chk++; if (rsp_fault[k] !== m_fault[k]) begin n_fail++; $display("FAIL rnd_fault L%0d n%0d: got %b want %b", k+1, n, rsp_fault[k], m_fault[k]); end
        tick();
      end
      set_in(k, 1'b1, 1'b0, 32'h0, 1'b0);
    end
  endtask

  initial begin
    for (int k = 0; k < NL; k++) begin
      m_rsp[k] = -1; m_txn[k] = '0; m_instr[k] = 'x; m_addr[k] = 'x; m_fault[k] = 1'bx;
    end
    @(posedge clk); #1;
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_faults();
    test_flush();
    test_reset_midwait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Latency-configurable instruction-memory responder: the target side of the fetch stage's instruction-request interface. It replaces the zero-latency combinational instruction ROM and accepts one fetch request at a time over a valid/ready handshake. It returns the 32-bit instruction word, echoed address and fault flag a programmable number of cycles later. Sits between the fetch stage (initiator) and the word-addressed instruction store; `busy`/`req_ready` feed the hazard unit's fetch stall.

## Interface

Parameters:
- `XLEN`, `riscv_pkg::XLEN` (32): address width.
- `DEPTH`, 1024: memory size in 32-bit words; power of two, ≥ 2.
- `LATENCY`, 2: cycles from request acceptance to response; legal range 1..15.
- `INIT_FILE`, "imem.hex": `$readmemh` image loaded at elaboration.
- `NOP`, 32'h0000_0013: word returned on a faulting request (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `req_valid`  in  1  fetch presents a request.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_addr`  in  XLEN  byte address of the instruction (PCF).
- `flush`  in  1  redirect (PCSrcE); cancels any in-flight request.
- `rsp_valid`  out  1  single-cycle pulse: response data valid.
- `rsp_instr`  out  32  instruction word.
- `rsp_addr`  out  XLEN  address of the request being answered.
- `rsp_fault`  out  1  request was misaligned or out of range.
- `busy`  out  1  a request is in flight (state ≠ IDLE).

## Operation

- Acceptance: a request is accepted on an edge where `req_valid && req_ready` is 1.
  - `req_addr` is captured into the address register at that edge.
  - Word index = `req_addr[2 +: $clog2(DEPTH)]`.
- Fault:
  - Misaligned: `req_addr[1:0] != 0`.
  - Out of range: `req_addr >= DEPTH*4`.
  - On fault: `rsp_instr = NOP` and `rsp_fault = 1`; memory is not consulted.
- Only one request is outstanding. The responder never buffers more than one.
- States:
  - IDLE: `req_ready = 1`. On acceptance, go to WAIT with `cnt = LATENCY-1`.
  - WAIT: `req_ready = 0`, `cnt` decrements each cycle. When `cnt == 0`, go to RESP.
    - With LATENCY=1, acceptance goes directly to RESP.
  - RESP: `rsp_valid = 1` for exactly this cycle, and `req_ready = 1`.
    - Acceptance in RESP goes to WAIT/RESP per the LATENCY rule (back-to-back issue).
    - Otherwise go to IDLE.
- `rsp_instr`, `rsp_addr` and `rsp_fault` are registered. They update only on the entry edge into RESP and hold their values until the next RESP entry.
- Flush:
  - When `flush = 1`, `req_ready` is forced to 0 and `rsp_valid` is forced to 0 combinationally.
  - Next state is IDLE regardless of the current state; `cnt` is cleared.
  - A request presented in a flush cycle is not accepted. Fetch re-presents it (the target) the following cycle.
- `busy = (state != IDLE)`.
- Reset (`rst = 0` at an edge):
  - State goes to IDLE and `cnt` to 0.
  - Registered outputs reset: `rsp_instr = NOP`, `rsp_addr = 0`, `rsp_fault = 0`.
  - `req_ready`, `rsp_valid` and `busy` are 0 during reset. `rsp_valid`/`busy` are 0 while in IDLE.
  - Reset mid-WAIT or mid-RESP drops the transaction; no response is ever produced for it.
- The memory array is not cleared by reset.

## Timing

- Request accepted at edge t gives `rsp_valid = 1` in the cycle after edge t+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Sustained throughput is one request per LATENCY cycles.
  - LATENCY=1 gives 1 instruction/cycle: `req_ready` stays 1 through back-to-back RESP cycles.
- `req_ready` is a function of state and `flush` only; it has no combinational path from `req_valid` or `req_addr`.
- `rsp_valid` depends combinationally on state and `flush`.
- Flush asserted in the same cycle as RESP suppresses that response. The registered data still changes, but `rsp_valid` stays 0.
- Flush while IDLE has no effect other than forcing `req_ready = 0` for that cycle.
- Simultaneous reset and flush: reset wins (same result).
- First acceptance after reset release: earliest at the first edge with `rst = 1`, since IDLE drives `req_ready = 1` once out of reset.

## Test plan

1. Reset/idle, LATENCY=2: hold `rst = 0` 3 cycles, then release. Required:
   - During reset: `req_ready = 0`, `rsp_valid = 0`, `rsp_instr = 32'h13`, `rsp_addr = 0`.
   - First cycle after release: `req_ready = 1`, `busy = 0`.
2. Basic fetch, LATENCY=2: image word[3] = 32'h00500093. Request `req_addr = 32'h0000000C`, accepted at edge t. Required:
   - `rsp_valid` high for one cycle, 2 cycles later.
   - `rsp_instr = 32'h00500093`, `rsp_addr = 32'h0C`, `rsp_fault = 0`.
   - `req_ready = 0` in the WAIT cycle.
3. Back-to-back, LATENCY=1: hold `req_valid` with addresses 0x0, 0x4, 0x8 on consecutive cycles. Required:
   - `rsp_valid` is 1 for 3 consecutive cycles, starting the cycle after the first acceptance.
   - `rsp_addr` sequence is 0x0, 0x4, 0x8.
   - `req_ready` stays 1 throughout.
4. Faults: request 0x00000006 (misaligned), then `DEPTH*4` = 0x00001000 (out of range). Required for each:
   - `rsp_fault = 1`, `rsp_instr = 32'h00000013`, with the correct `rsp_addr`.
5. Flush mid-flight, LATENCY=3: accept 0x10, assert `flush` one cycle later, then present 0x40 the cycle after. Required:
   - No response is produced for 0x10.
   - 0x40 is accepted and answered 3 cycles after its acceptance.
6. Reset mid-WAIT, LATENCY=4: accept 0x20, drive `rst = 0` two cycles later for 1 cycle. Required:
   - No `rsp_valid` for 0x20.
   - After release: `busy = 0`, `req_ready = 1`.
